// File: rtl/noc_pkg.sv
// Shared types and helpers for the NoC input port.
// Flit layout, port encoding and XY routing.
package noc_pkg;

    localparam int FLIT_W  = 16;
    localparam int TYPE_HI = 15;
    localparam int TYPE_LO = 14;
    localparam int DX_HI   = 7;
    localparam int DX_LO   = 4;
    localparam int DY_HI   = 3;
    localparam int DY_LO   = 0;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic [2:0] {
        PORT_LOCAL = 3'd0,
        PORT_NORTH = 3'd1,
        PORT_SOUTH = 3'd2,
        PORT_EAST  = 3'd3,
        PORT_WEST  = 3'd4
    } port_e;

    // Dimension-ordered routing: resolve X first, then Y.
    function automatic port_e xy_route(
        input logic [3:0] dst_x,
        input logic [3:0] dst_y,
        input logic [3:0] loc_x,
        input logic [3:0] loc_y
    );
        port_e p;
        if (dst_x > loc_x)      p = PORT_EAST;
        else if (dst_x < loc_x) p = PORT_WEST;
        else if (dst_y > loc_y) p = PORT_NORTH;
        else if (dst_y < loc_y) p = PORT_SOUTH;
        else                    p = PORT_LOCAL;
        return p;
    endfunction

endpackage

// File: rtl/noc_fifo.sv
// Circular flit buffer with occupancy counter.
// Full/empty come from the count; pointers wrap naturally.
module noc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Empty buffer presents zero rather than stale storage.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Pointer and count state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are qualified by count so need no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/noc_input_port.sv
// Credit-based NoC input port: flit buffer, packet framing
// tracker, XY route selection and credit return.
module noc_input_port
    import noc_pkg::*;
#(
    parameter int         DEPTH   = 4,
    parameter logic [3:0] LOCAL_X = 4'd0,
    parameter logic [3:0] LOCAL_Y = 4'd0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [FLIT_W-1:0]          data,
    output logic                       credit,
    output logic                       out_valid,
    output logic [FLIT_W-1:0]          out_data,
    output logic [2:0]                 out_port,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       frame_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_e;

    state_e     state_q;
    port_e      route_q;
    logic       credit_q;
    logic       overflow_q;
    logic       frame_err_q;
    logic       full, empty, pop;
    flit_type_e hd_type;
    port_e      hd_route;
    port_e      port_sel;
    logic       hd_is_start;

    noc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FLIT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (enable),
        .pop_i   (pop),
        .wdata_i (data),
        .rdata_o (out_data),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign out_valid   = !empty;
    assign pop         = out_valid && out_ready;
    assign hd_type     = flit_type_e'(out_data[TYPE_HI:TYPE_LO]);
    assign hd_is_start = (hd_type == FLIT_HEAD) || (hd_type == FLIT_SINGLE);
    assign hd_route    = xy_route(out_data[DX_HI:DX_LO],
                                  out_data[DY_HI:DY_LO],
                                  LOCAL_X, LOCAL_Y);

    // Inside a packet the latched route holds; between packets
    // a packet-start flit routes itself, anything else goes local.
    always_comb begin
        port_sel = PORT_LOCAL;
        if (state_q == ST_PKT) port_sel = route_q;
        else if (hd_is_start)  port_sel = hd_route;
    end

    assign out_port  = port_sel;
    assign credit    = credit_q;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

    // Framing FSM with route latch, credit return and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            route_q     <= PORT_LOCAL;
            credit_q    <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            credit_q <= pop;
            if (enable && full) overflow_q <= 1'b1;
            if (pop) begin
                unique case (hd_type)
                    FLIT_HEAD: begin
                        if (state_q == ST_PKT) frame_err_q <= 1'b1;
                        state_q <= ST_PKT;
                        route_q <= hd_route;
                    end
                    FLIT_SINGLE: begin
                        if (state_q == ST_PKT) frame_err_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                    FLIT_BODY: begin
                        if (state_q == ST_IDLE) frame_err_q <= 1'b1;
                    end
                    FLIT_TAIL: begin
                        if (state_q == ST_IDLE) frame_err_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_noc_input_port.sv
// Scoreboard bench for noc_input_port: directed packet cases
// plus randomized traffic against a flit-stream model.
module tb_noc_input_port;

    localparam int         DEPTH = 4;
    localparam logic [3:0] LX    = 4'd2;
    localparam logic [3:0] LY    = 4'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] data = '0;
    logic        out_ready = 1'b0;
    logic        credit, out_valid, overflow, frame_err;
    logic [15:0] out_data;
    logic [2:0]  out_port;
    logic [2:0]  count;

    noc_input_port #(
        .DEPTH   (DEPTH),
        .LOCAL_X (LX),
        .LOCAL_Y (LY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .data      (data),
        .credit    (credit),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_port  (out_port),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  port;
        bit          err;
    } item_t;

    item_t       exp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    bit          ovf_exp = 0;
    bit          ferr_exp = 0;
    bit          credit_exp = 0;
    bit          pop_flag = 0;
    bit          en_prev = 0;
    logic [15:0] d_prev = '0;
    bit          in_pkt = 0;
    logic [2:0]  cur_route = 3'd0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    // Route chosen by comparing destination against this router.
    function automatic logic [2:0] ref_route(logic [15:0] f);
        logic [3:0] dx, dy;
        dx = f[7:4];
        dy = f[3:0];
        if (dx > LX) return 3'd3;
        if (dx < LX) return 3'd4;
        if (dy > LY) return 3'd1;
        if (dy < LY) return 3'd2;
        return 3'd0;
    endfunction

    // Stream-level framing: a head opens a packet, tail/single
    // close it; out-of-place flits are flagged.
    function automatic void model_push(logic [15:0] f);
        item_t      it;
        logic [1:0] t;
        t = f[15:14];
        it.data = f;
        if (!in_pkt) begin
            it.err  = (t == 2'b00) || (t == 2'b10);
            it.port = it.err ? 3'd0 : ref_route(f);
        end else begin
            it.err  = (t == 2'b01) || (t == 2'b11);
            it.port = cur_route;
        end
        if (t == 2'b01) begin
            in_pkt    = 1;
            cur_route = ref_route(f);
        end else if (t != 2'b00) begin
            in_pkt = 0;
        end
        exp_q.push_back(it);
    endfunction

    // Account for the flit offered at the edge just passed, then
    // drive the next cycle's inputs.
    task automatic step(bit e, logic [15:0] d, bit r);
        @(posedge clk);
        #1;
        if (en_prev) begin
            if (exp_q.size() + int'(pop_flag) < DEPTH) model_push(d_prev);
            else ovf_exp = 1;
        end
        pop_flag  = 0;
        enable    = e;
        data      = d;
        out_ready = r;
        en_prev   = e;
        d_prev    = d;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        enable    = 1'b0;
        out_ready = 1'b0;
        en_prev   = 0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_credit", 32'(credit), 32'd0);
        chk("rst_port", 32'(out_port), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        exp_q.delete();
        ovf_exp    = 0;
        ferr_exp   = 0;
        credit_exp = 0;
        pop_flag   = 0;
        in_pkt     = 0;
        cur_route  = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [15:0] rand_flit();
        logic [15:0] f;
        f        = 16'($urandom);
        f[7:4]   = 4'($urandom_range(0, 4));
        f[3:0]   = 4'($urandom_range(0, 3));
        return f;
    endfunction

    // Monitor: compare visible state against the scoreboard and
    // retire the head entry when the crossbar takes it.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                credit_exp = 0;
                continue;
            end
            chk("count", 32'(count), 32'(exp_q.size()));
            chk("valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("credit", 32'(credit), 32'(credit_exp));
            chk("overflow", 32'(overflow), 32'(ovf_exp));
            chk("frame_err", 32'(frame_err), 32'(ferr_exp));
            credit_exp = 0;
            if (exp_q.size() != 0) begin
                chk("out_data", 32'(out_data), 32'(exp_q[0].data));
                chk("out_port", 32'(out_port), 32'(exp_q[0].port));
                if (out_ready) begin
                    item_t it;
                    it = exp_q.pop_front();
                    if (it.err) ferr_exp = 1;
                    credit_exp = 1;
                    pop_flag   = 1;
                end
            end
        end
    end

    initial begin
        #3;
        chk("init_valid", 32'(out_valid), 32'd0);
        chk("init_data", 32'(out_data), 32'd0);
        chk("init_port", 32'(out_port), 32'd0);
        chk("init_count", 32'(count), 32'd0);
        chk("init_credit", 32'(credit), 32'd0);
        chk("init_flags", 32'({overflow, frame_err}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single flit, held then popped.
        step(1, 16'hC012, 0);
        step(0, 16'h0, 0);
        step(0, 16'h0, 1);
        step(0, 16'h0, 0);
        step(0, 16'h0, 0);

        // Head/body/tail streamed straight through.
        step(1, 16'h4030, 1);
        step(1, 16'h0000, 1);
        step(1, 16'h8000, 1);
        repeat (4) step(0, 16'h0, 1);

        // Overfill with crossbar stalled, then drain.
        for (int i = 0; i < 5; i++) step(1, 16'hC000 | 16'(i), 0);
        step(0, 16'h0, 0);
        repeat (6) step(0, 16'h0, 1);

        // Push while full with a same-cycle pop.
        for (int i = 0; i < 4; i++) step(1, 16'hC011, 0);
        step(1, 16'hC022, 1);
        step(0, 16'h0, 0);
        repeat (5) step(0, 16'h0, 1);

        // Stray body flit outside a packet.
        do_reset();
        step(1, 16'h0000, 1);
        repeat (3) step(0, 16'h0, 1);

        // Reset with a partial packet buffered.
        step(1, 16'h4031, 0);
        step(1, 16'h0001, 0);
        step(1, 16'h0002, 0);
        step(0, 16'h0, 0);
        do_reset();

        // Random traffic with phase-varying back-pressure.
        for (int ph = 0; ph < 12; ph++) begin
            int rp;
            rp = $urandom_range(10, 100);
            for (int c = 0; c < 50; c++) begin
                bit e, r;
                e = ($urandom_range(0, 99) < 70);
                r = ($urandom_range(0, 99) < rp);
                step(e, rand_flit(), r);
            end
        end
        repeat (8) step(0, 16'h0, 1);
        step(0, 16'h0, 0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
